// File: rtl/arm_pkg.sv
// Shared definitions for the pipeline's data-memory path: SRAM controller state
// encoding and the external SRAM data width.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } sram_state_t;

  localparam int unsigned SRAM_DW = 16;

endpackage

// File: rtl/sram_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two half-word SRAM accesses of
// ACCESS_CYCLES cycles each, holding ready low until the word has transferred.
module sram_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned SRAM_ADDR_W   = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DW-1:0]     sram_wdata,
  input  logic [SRAM_DW-1:0]     sram_rdata,
  output logic                   sram_we_n,
  output logic                   sram_oe
);

  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  sram_state_t            state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   is_write_q, is_write_d;
  logic [31:0]            read_data_q;
  logic [SRAM_ADDR_W-1:0] addr_q;

  logic req;
  logic last;
  logic active;

  assign req    = mem_read | mem_write;
  assign last   = (cnt_q == LastCnt);
  assign active = (state_q == LO) || (state_q == HI);

  // Byte-offset and bits above the SRAM range are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:SRAM_ADDR_W+1], address[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = LO;
          cnt_d      = 4'd0;
          is_write_d = mem_write;
        end
      end
      LO: begin
        if (last) begin
          state_d = HI;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
    end
  end

  // Address is registered so it stays stable across each whole half-word window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      read_data_q <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        addr_q <= {address[SRAM_ADDR_W:2], 1'b0};
      end else if (state_q == LO && last) begin
        addr_q[0] <= 1'b1;
      end
      if (!is_write_q && last) begin
        if (state_q == LO) begin
          read_data_q[15:0] <= sram_rdata;
        end else if (state_q == HI) begin
          read_data_q[31:16] <= sram_rdata;
        end
      end
    end
  end

  always_comb begin
    ready      = ((state_q == IDLE) && !req) || (state_q == DONE);
    sram_oe    = active && is_write_q;
    sram_we_n  = !(active && is_write_q);
    sram_wdata = '0;
    if (active && is_write_q) begin
      sram_wdata = (state_q == LO) ? write_data[15:0] : write_data[31:16];
    end
  end

  assign read_data = read_data_q;
  assign sram_addr = addr_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: transaction-level model with a small SRAM array, random
// loads/stores on an AC=2 instance, plus directed AC=1 and AC=4 instances.
module tb_sram_ctrl;

  localparam int AC = 2;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance (AC=2)
  logic          mem_read, mem_write;
  logic [31:0]   address, write_data, read_data;
  logic          ready, sram_we_n, sram_oe;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata, sram_rdata;
  logic [15:0]   mem [0:255];

  assign sram_rdata = mem[sram_addr[7:0]];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_wdata;

  sram_ctrl #(.ACCESS_CYCLES(AC), .SRAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_we_n(sram_we_n), .sram_oe(sram_oe)
  );

  // AC=1 instance
  logic          rd1;
  logic [31:0]   r1_data;
  logic          r1_ready, r1_we_n, r1_oe;
  logic [AW-1:0] r1_addr;
  logic [15:0]   r1_wdata;
  logic [15:0]   r1_rdata = 16'h1234;
  logic          wr_off = 1'b0;
  logic [31:0]   addr_c = 32'h40;
  logic [31:0]   wd_c = 32'hCAFEF00D;

  sram_ctrl #(.ACCESS_CYCLES(1), .SRAM_ADDR_W(AW)) dut1 (
    .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr_off),
    .address(addr_c), .write_data(wd_c), .read_data(r1_data), .ready(r1_ready),
    .sram_addr(r1_addr), .sram_wdata(r1_wdata), .sram_rdata(r1_rdata),
    .sram_we_n(r1_we_n), .sram_oe(r1_oe)
  );

  // AC=4 instance
  logic          wr4;
  logic          rd_off = 1'b0;
  logic [31:0]   r4_data;
  logic          r4_ready, r4_we_n, r4_oe;
  logic [AW-1:0] r4_addr;
  logic [15:0]   r4_wdata;
  logic [15:0]   r4_rdata = 16'h0;

  sram_ctrl #(.ACCESS_CYCLES(4), .SRAM_ADDR_W(AW)) dut4 (
    .clk(clk), .rst(rst), .mem_read(rd_off), .mem_write(wr4),
    .address(addr_c), .write_data(wd_c), .read_data(r4_data), .ready(r4_ready),
    .sram_addr(r4_addr), .sram_wdata(r4_wdata), .sram_rdata(r4_rdata),
    .sram_we_n(r4_we_n), .sram_oe(r4_oe)
  );

  // Transaction model: t is the cycle index within the current transaction.
  bit          busy;
  int          t;
  bit          m_wr;
  logic [16:0] m_a;
  logic [31:0] m_wd;
  logic [31:0] rd_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    logic req;
    logic half;
    @(negedge clk);
    req = mem_read | mem_write;
    if (!busy) begin
      chk("ready_idle", {31'b0, ready}, {31'b0, !req});
      chk("we_n_idle", {31'b0, sram_we_n}, 32'd1);
      chk("oe_idle", {31'b0, sram_oe}, 32'd0);
      chk("wdata_idle", {16'b0, sram_wdata}, 32'd0);
    end else if (t <= 2 * AC) begin
      half = (t > AC);
      chk("ready_busy", {31'b0, ready}, 32'd0);
      chk("we_n_busy", {31'b0, sram_we_n}, {31'b0, !m_wr});
      chk("oe_busy", {31'b0, sram_oe}, {31'b0, m_wr});
      chk("wdata_busy", {16'b0, sram_wdata},
          m_wr ? {16'b0, (half ? m_wd[31:16] : m_wd[15:0])} : 32'd0);
      chk("sram_addr", {14'b0, sram_addr}, {14'b0, m_a, half});
    end else begin
      chk("ready_done", {31'b0, ready}, 32'd1);
      chk("we_n_done", {31'b0, sram_we_n}, 32'd1);
      chk("oe_done", {31'b0, sram_oe}, 32'd0);
      chk("wdata_done", {16'b0, sram_wdata}, 32'd0);
    end
    chk("read_data", read_data, rd_exp);
  endtask

  task automatic advance();
    logic [17:0] ix;
    @(posedge clk);
    if (!busy) begin
      if (mem_read | mem_write) begin
        busy = 1'b1;
        t    = 1;
        m_wr = mem_write;
        m_a  = address[18:2];
        m_wd = write_data;
      end
    end else begin
      if (!m_wr && t == AC) begin
        ix = {m_a, 1'b0};
        rd_exp[15:0] = mem[ix[7:0]];
      end
      if (!m_wr && t == 2 * AC) begin
        ix = {m_a, 1'b1};
        rd_exp[31:16] = mem[ix[7:0]];
      end
      if (t == 2 * AC + 1) busy = 1'b0;
      else t++;
    end
    #1;
  endtask

  initial begin
    int we_low;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
    rd1 = 1'b0; wr4 = 1'b0;
    busy = 1'b0; t = 0; m_wr = 1'b0; m_a = '0; m_wd = '0; rd_exp = '0;
    #12;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_sram_addr", {14'b0, sram_addr}, 32'd0);
    chk("rst_wdata", {16'b0, sram_wdata}, 32'd0);
    chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'b0, sram_oe}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Store 0xDEADBEEF at 0x40
    address = 32'h40; write_data = 32'hDEADBEEF; mem_write = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      sample();
      if (c == 1 || c == 2) begin
        chk("st_lo_addr", {14'b0, sram_addr}, 32'h20);
        chk("st_lo_wdata", {16'b0, sram_wdata}, 32'hBEEF);
        chk("st_lo_we_n", {31'b0, sram_we_n}, 32'd0);
      end
      if (c == 3 || c == 4) begin
        chk("st_hi_addr", {14'b0, sram_addr}, 32'h21);
        chk("st_hi_wdata", {16'b0, sram_wdata}, 32'hDEAD);
      end
      chk("st_ready", {31'b0, ready}, (c == 5) ? 32'd1 : 32'd0);
      advance();
    end
    mem_write = 1'b0;

    // Load back from 0x40
    mem_read = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      sample();
      chk("ld_ready", {31'b0, ready}, (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) chk("ld_data", read_data, 32'hDEADBEEF);
      advance();
    end
    mem_read = 1'b0;

    // Both requests: write wins, read_data untouched
    address = 32'h0000_0088; write_data = 32'h1357_9BDF; mem_read = 1'b1; mem_write = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      sample();
      if (c == 1) chk("both_we_n", {31'b0, sram_we_n}, 32'd0);
      advance();
    end
    chk("both_read_data", read_data, 32'hDEADBEEF);
    mem_read = 1'b0; mem_write = 1'b0;

    // Asynchronous reset in the middle of LO
    address = 32'h44; write_data = 32'h0BAD_F00D; mem_write = 1'b1;
    sample(); advance();
    sample();
    chk("mid_lo_we_n_before", {31'b0, sram_we_n}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort_we_n", {31'b0, sram_we_n}, 32'd1);
    chk("abort_oe", {31'b0, sram_oe}, 32'd0);
    chk("abort_ready_req", {31'b0, ready}, 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    mem_write = 1'b0;
    #1;
    chk("abort_ready_idle", {31'b0, ready}, 32'd1);
    busy = 1'b0; rd_exp = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Random traffic, inputs held while a transaction is in flight
    for (int n = 0; n < 600; n++) begin
      if (!busy) begin
        int r;
        r = $urandom_range(0, 3);
        mem_read   = (r == 1) || (r == 3);
        mem_write  = (r == 2) || (r == 3);
        address    = $urandom;
        write_data = $urandom;
      end
      sample();
      advance();
    end
    while (busy) begin
      sample();
      advance();
    end
    mem_read = 1'b0; mem_write = 1'b0;

    // AC=1: two back-to-back loads, ready high exactly in cycles 3 and 7
    rd1 = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      chk("ac1_ready", {31'b0, r1_ready}, (c == 3 || c == 7) ? 32'd1 : 32'd0);
      if (c == 3 || c == 7) chk("ac1_data", r1_data, 32'h12341234);
      @(posedge clk); #1;
    end
    rd1 = 1'b0;
    @(negedge clk);
    chk("ac1_ready_after", {31'b0, r1_ready}, 32'd1);
    @(posedge clk); #1;

    // AC=4 store: 8 strobe cycles, ready rises in cycle 9
    wr4 = 1'b1;
    we_low = 0;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      chk("ac4_ready", {31'b0, r4_ready}, (c == 9) ? 32'd1 : 32'd0);
      chk("ac4_we_n", {31'b0, r4_we_n}, (c >= 1 && c <= 8) ? 32'd0 : 32'd1);
      if (!r4_we_n) we_low++;
      @(posedge clk); #1;
    end
    wr4 = 1'b0;
    chk("ac4_we_low_count", we_low, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Multi-cycle data-memory controller that sits between the MEM pipeline stage and an external 16-bit SRAM. It turns each 32-bit load/store request into two sequenced half-word SRAM accesses with a programmable number of wait cycles per access. It drives `ready` low to freeze the pipeline until the word transfer is complete.

## Interface
Parameters:
- `ACCESS_CYCLES`, 2: cycles each half-word SRAM access is held; legal range 1..15.
- `SRAM_ADDR_W`, 18: SRAM half-word address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  load request; held stable by the frozen pipeline until `ready`.
- `mem_write`  in  1  store request; held stable until `ready`.
- `address`  in  32  byte address from the ALU result; bits [1:0] are ignored.
- `write_data`  in  32  store data (val_Rm).
- `read_data`  out  32  load data; valid while `ready`=1 in the DONE cycle, then held.
- `ready`  out  1  0 = freeze the pipeline; 1 = the stage may advance.
- `sram_addr`  out  SRAM_ADDR_W  half-word address, equal to {address[SRAM_ADDR_W:2], half}.
- `sram_wdata`  out  16  half-word being written.
- `sram_rdata`  in  16  half-word read from the SRAM.
- `sram_we_n`  out  1  active-low write strobe.
- `sram_oe`  out  1  1 = the top-level tristate drives `sram_wdata` onto the DQ bus.

## Operation
- FSM states: IDLE, LO, HI, DONE. A 4-bit counter `cnt` runs in LO and HI.
- IDLE:
  - If `mem_write` or `mem_read` is asserted, capture the operation type and go to LO with `cnt`=0.
  - `mem_write` has priority if both are asserted; `mem_read` is then ignored for that transaction.
- LO: `half`=0. `cnt` increments each cycle. On `cnt`=ACCESS_CYCLES-1:
  - read: latch `sram_rdata` into `read_data[15:0]`.
  - Go to HI with `cnt`=0.
- HI: `half`=1, with the same counting. On the last cycle:
  - read: latch `sram_rdata` into `read_data[31:16]`.
  - Go to DONE.
- DONE: lasts one cycle, then IDLE. A request still present in the following IDLE cycle is treated as a new transaction; the pipeline has advanced by then, so it is a new instruction.
- Write outputs:
  - `sram_we_n`=0 for all LO/HI cycles of a write.
  - `sram_oe`=1 for all LO/HI cycles of a write.
  - `sram_wdata` = `write_data[15:0]` in LO and `write_data[31:16]` in HI; 0 otherwise.
- Idle outputs: `sram_we_n`=1 and `sram_oe`=0 in IDLE, in DONE, and during reads.
- `ready` (combinational from state and inputs):
  - 1 in IDLE when neither request is asserted.
  - 1 in DONE.
  - 0 otherwise, including the IDLE cycle in which a request first appears.
- Reset values:
  - state=IDLE, `cnt`=0.
  - `read_data`=0, `sram_addr`=0, `sram_wdata`=0.
  - `sram_we_n`=1, `sram_oe`=0.
  - `ready` follows its rule: it equals 1 when no request is asserted.
- Reset asserted mid-transaction aborts immediately (asynchronously). The partially written word is left as-is in the SRAM, and no DONE cycle is produced.

## Timing
- Cycle 0 is the request-present IDLE cycle, with `ready`=0.
- LO occupies cycles 1..AC, HI occupies AC+1..2AC, and DONE is at cycle 2AC+1 with `ready`=1.
- The pipeline therefore stalls for 2·ACCESS_CYCLES+1 cycles per memory instruction. With the default AC=2: 5 stall cycles, and `ready` rises in cycle 5.
- `sram_addr` is stable for each full LO/HI window. The low-half address is output from cycle 1.
- Back-to-back requests: the second request's IDLE (cycle 0) follows DONE directly, so there is no extra bubble.
- Non-memory instructions never see `ready`=0.

## Structure
- The shared package `arm_pkg` holds:
  - the state enum `sram_state_t` {IDLE, LO, HI, DONE};
  - the SRAM data width constant `SRAM_DW`=16.
- Single flat module. No sub-module is required; the wait counter is inline.
- The MEM stage instantiates `sram_ctrl` in place of its memory model. `ready` is routed to the hazard/freeze logic.

## Test plan
- Reset with no request: all outputs at their reset values and `ready`=1. Assert `rst` mid-LO: state returns to IDLE asynchronously and `sram_we_n`=1 immediately.
- Store `write_data`=0xDEADBEEF at `address`=0x40 (AC=2):
  - cycles 1–2: `sram_addr`=0x20, `sram_wdata`=0xBEEF, `sram_we_n`=0;
  - cycles 3–4: `sram_addr`=0x21, `sram_wdata`=0xDEAD;
  - cycle 5: `ready`=1.
- Load from 0x40 with the SRAM model holding 0xBEEF/0xDEAD: `read_data`=0xDEADBEEF in cycle 5, with `ready` low in cycles 0–4.
- `mem_read` and `mem_write` both high: a write transaction is performed and `read_data` is unchanged.
- Two back-to-back loads with AC=1: `ready` is high exactly in cycles 3 and 7, with no extra idle cycle between transactions.
- AC=4 store: `sram_we_n` is low for exactly 8 consecutive cycles and `ready` rises in cycle 9.
